key_conditioner: RTL and testbench

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_conditioner.sv | 133 +++++++++++++
 tb/tb_key_conditioner.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
//
// Purpose:
//   Conditions asynchronous, active-low push-button pins for use as core
//   interrupt sources. Each channel is synchronized, then debounced: a change
//   is accepted only after DebounceCycles consecutive synchronized samples
//   that disagree with the current stable state. Edge pulses and an optional
//   sticky press flag are derived from the accepted transitions.
//
// Parameters:
//   Channels       number of independent button channels (1..32)
//   DebounceCycles consecutive stable samples needed to accept a change (>= 1)
//   SyncStages     synchronizer depth in flops (>= 2)
//
// Ports:
//   clk      in   system clock (single domain)
//   rst_n    in   asynchronous active-low reset
//   raw_n    in   [Channels] asynchronous button pins, 0 = pressed
//   clear    in   [Channels] synchronous pending clear, active high
//   level    out  [Channels] debounced pressed state, 1 = pressed
//   rise     out  [Channels] one-cycle press pulse
//   fall     out  [Channels] one-cycle release pulse
//   pending  out  [Channels] sticky press flag
//
// Configuration:
//   KEY_CONDITIONER__PENDING_LATCH_EN
//     defined   : pending sets on a press and clears on clear (set wins).
//     undefined : pending is tied to 0, clear is ignored, no flag registers.
// -----------------------------------------------------------------------------
module key_conditioner #(
  parameter int Channels       = 4,
  parameter int DebounceCycles = 500_000,
  parameter int SyncStages     = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [Channels-1:0] raw_n,
  input  logic [Channels-1:0] clear,
  output logic [Channels-1:0] level,
  output logic [Channels-1:0] rise,
  output logic [Channels-1:0] fall,
  output logic [Channels-1:0] pending
);

  localparam int            CntW    = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(DebounceCycles - 1);

  // Synchronizer chain: stage 0 samples the pins, the last stage is the only
  // one the debouncer looks at.
  logic [Channels-1:0] sync_q [SyncStages];
  logic [Channels-1:0] sample;

  logic [Channels-1:0] stable_q;
  logic [CntW-1:0]     cnt_q [Channels];
  logic [CntW-1:0]     cnt_d [Channels];
  logic [Channels-1:0] differ;
  logic [Channels-1:0] toggle;
  logic [Channels-1:0] rise_q;
  logic [Channels-1:0] fall_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // synchronizer chain into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Released level for an active-low pin, so a held button is seen as a
      // fresh press after reset.
      for (int s = 0; s < SyncStages; s++) sync_q[s] <= '1;
    end else begin
      sync_q[0] <= raw_n;
      for (int s = 1; s < SyncStages; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sample = ~sync_q[SyncStages-1];

  // Per-channel debounce decision. The counter tracks how many consecutive
  // samples have disagreed with the stable state; the edge on which it would
  // reach DebounceCycles is the edge that accepts the change.
  // NOTE: every output of this block gets a default before any conditional
  // assignment, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    differ = '0;
    toggle = '0;
    for (int c = 0; c < Channels; c++) begin
      cnt_d[c]  = '0;
      differ[c] = sample[c] ^ stable_q[c];
      toggle[c] = differ[c] && (cnt_q[c] == LastCnt);
      if (differ[c] && !toggle[c]) cnt_d[c] = cnt_q[c] + CntW'(1);
    end
  end

  // NOTE: the counter array is small per-channel state, not a memory, so it is
  // reset explicitly; a partial count must not survive a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      for (int c = 0; c < Channels; c++) cnt_q[c] <= '0;
    end else begin
      stable_q <= stable_q ^ toggle;
      // Pulses are produced on the same edge the stable state flips, so they
      // line up with the first cycle of the new level.
      rise_q   <= toggle & ~stable_q;
      fall_q   <= toggle &  stable_q;
      for (int c = 0; c < Channels; c++) cnt_q[c] <= cnt_d[c];
    end
  end

  assign level = stable_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

`ifdef KEY_CONDITIONER__PENDING_LATCH_EN
  logic [Channels-1:0] pending_q;

  // A press arriving on the same edge as a clear wins, so no event is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= (pending_q & ~clear) | (toggle & ~stable_q);
  end

  assign pending = pending_q;
`else
  logic unused_clear;

  assign unused_clear = ^clear;
  assign pending      = '0;
`endif

endmodule

// File: tb/tb_key_conditioner.sv
// -----------------------------------------------------------------------------
// tb_key_conditioner
//
// Directed bench for key_conditioner with Channels=4, DebounceCycles=4,
// SyncStages=2: reset values, clean press, bounce rejection, release,
// pending latch set/clear priority, and reset in the middle of a count.
// Expected pending values follow KEY_CONDITIONER__PENDING_LATCH_EN.
// -----------------------------------------------------------------------------
module tb_key_conditioner;

  localparam int Channels = 4;

`ifdef KEY_CONDITIONER__PENDING_LATCH_EN
  localparam bit PendEn = 1'b1;
`else
  localparam bit PendEn = 1'b0;
`endif

  logic                clk;
  logic                rst_n;
  logic [Channels-1:0] raw_n;
  logic [Channels-1:0] clear;
  logic [Channels-1:0] level;
  logic [Channels-1:0] rise;
  logic [Channels-1:0] fall;
  logic [Channels-1:0] pending;

  int tests_run = 0;
  int tests_failed = 0;

  logic [Channels-1:0] exp_pend;

  key_conditioner #(
    .Channels      (Channels),
    .DebounceCycles(4),
    .SyncStages    (2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_n  (raw_n),
    .clear  (clear),
    .level  (level),
    .rise   (rise),
    .fall   (fall),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance past one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pending(input string tag);
    check(tag, 32'(pending), 32'(PendEn ? exp_pend : '0));
  endtask

  initial begin
    // ---------------- Reset, before any clock edge ----------------
    rst_n    = 1'b0;
    raw_n    = 4'hF;
    clear    = 4'h0;
    exp_pend = 4'h0;
    #1;
    check("reset_level",   32'(level),   32'h0);
    check("reset_rise",    32'(rise),    32'h0);
    check("reset_fall",    32'(fall),    32'h0);
    check("reset_pending", 32'(pending), 32'h0);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_level", 32'(level), 32'h0);

    // ---------------- Clean press on channel 0 ----------------
    @(negedge clk);
    raw_n = 4'b1110;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check($sformatf("press_wait_level_e%0d", e), 32'(level), 32'h0);
      check($sformatf("press_wait_rise_e%0d", e),  32'(rise),  32'h0);
    end
    tick();  // edge 6
    exp_pend = 4'b0001;
    check("press_level_e6",  32'(level), 32'h1);
    check("press_rise_e6",   32'(rise),  32'h1);
    check("press_fall_e6",   32'(fall),  32'h0);
    check_pending("press_pending_e6");
    tick();  // edge 7
    check("press_rise_e7",  32'(rise),  32'h0);
    check("press_level_e7", 32'(level), 32'h1);

    // ---------------- Release on channel 0 ----------------
    @(negedge clk);
    raw_n = 4'b1111;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check($sformatf("release_wait_level_e%0d", e), 32'(level), 32'h1);
      check($sformatf("release_wait_fall_e%0d", e),  32'(fall),  32'h0);
    end
    tick();  // edge 6
    check("release_level_e6", 32'(level), 32'h0);
    check("release_fall_e6",  32'(fall),  32'h1);
    check("release_rise_e6",  32'(rise),  32'h0);
    check_pending("release_pending_e6");
    tick();  // edge 7
    check("release_fall_e7", 32'(fall), 32'h0);

    // Clear channel 0 pending before the next scenario.
    @(negedge clk);
    clear = 4'b0001;
    tick();
    exp_pend = 4'b0000;
    @(negedge clk);
    clear = 4'b0000;
    check_pending("clear_ch0_pending");

    // ---------------- Bounce on channel 0 ----------------
    // Low before edges 1-3, high before edge 4, low from edge 5 on.
    // Accepted 6 edges after the final low transition: edge 10.
    for (int e = 1; e <= 10; e++) begin
      if (e > 1) @(negedge clk);
      raw_n = (e == 4) ? 4'b1111 : 4'b1110;
      tick();
      check($sformatf("bounce_level_e%0d", e), 32'(level), (e >= 10) ? 32'h1 : 32'h0);
      check($sformatf("bounce_rise_e%0d", e),  32'(rise),  (e == 10) ? 32'h1 : 32'h0);
    end
    exp_pend = 4'b0001;
    check_pending("bounce_pending");

    // Return channel 0 to released and clear its flag.
    @(negedge clk);
    raw_n = 4'b1111;
    clear = 4'b0001;
    repeat (7) tick();
    exp_pend = 4'b0000;
    @(negedge clk);
    clear = 4'b0000;
    check("bounce_released_level", 32'(level), 32'h0);
    check_pending("bounce_cleared_pending");

    // ---------------- Pending latch on channel 1 ----------------
    raw_n = 4'b1101;
    repeat (5) tick();
    @(negedge clk);
    clear = 4'b0010;  // coincides with the edge that raises rise[1]
    tick();           // edge 6
    exp_pend = 4'b0010;
    check("latch_rise_e6",  32'(rise),  32'h2);
    check("latch_level_e6", 32'(level), 32'h2);
    check_pending("latch_set_wins");
    @(negedge clk);
    clear = 4'b0000;
    tick();           // edge 7
    check_pending("latch_hold_e7");
    @(negedge clk);
    clear = 4'b0010;
    tick();           // edge 8
    exp_pend = 4'b0000;
    check_pending("latch_cleared_e8");
    @(negedge clk);
    clear = 4'b0000;

    // ---------------- Mid-count reset on channel 2 ----------------
    // Channel 1 stays pressed through reset and must be re-accepted too.
    raw_n = 4'b1001;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    exp_pend = 4'b0000;
    check("midreset_level", 32'(level), 32'h0);
    check("midreset_rise",  32'(rise),  32'h0);
    check_pending("midreset_pending");
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check($sformatf("midreset_wait_level_e%0d", e), 32'(level), 32'h0);
      check($sformatf("midreset_wait_rise_e%0d", e),  32'(rise),  32'h0);
    end
    tick();  // edge 6 after release
    exp_pend = 4'b0110;
    check("midreset_level_e6", 32'(level), 32'h6);
    check("midreset_rise_e6",  32'(rise),  32'h6);
    check("midreset_fall_e6",  32'(fall),  32'h0);
    check_pending("midreset_pending_e6");
    tick();
    check("midreset_rise_e7", 32'(rise), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
